// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    typedef enum logic {
        LOAD,
        RUN
    } imem_state_t;

    // Bit 0 = misaligned, bit 1 = out of range, so both faults OR together naturally.
    typedef enum logic [1:0] {
        F_NONE     = 2'b00,
        F_MISALIGN = 2'b01,
        F_RANGE    = 2'b10,
        F_BOTH     = 2'b11
    } imem_fault_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W instruction store: one write port, one registered read port.
// Latency: read data valid one clock after re; write commits on the clock edge.
// Backpressure: none; rdata holds its last value while re is low.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata read result.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset on the array or the read register so this maps onto block RAM;
    // contents survive a reset of the surrounding logic.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a program-load phase and a byte-addressed fetch handshake.
// Latency: an accepted fetch returns inst/fault exactly one cycle later.
// Backpressure: while inst_valid && stall the result holds and fetch_ready drops.
// Ports: clk/rst; prog_we/prog_addr/prog_data/prog_done/prog_count loader side;
//        fetch_req/fetch_addr/fetch_ready request side; stall/inst_valid/inst/
//        fault/fault_code decode side.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     prog_done,
    output logic [$clog2(DEPTH):0]   prog_count,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    input  logic                     stall,
    output logic                     inst_valid,
    output logic [DATA_W-1:0]        inst,
    output logic                     fault,
    output logic [1:0]               fault_code
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    imem_state_t       state_q, state_d;
    logic              inst_valid_q, inst_valid_d;
    imem_fault_t       fault_code_q, fault_code_d;
    logic [AW:0]       prog_count_q, prog_count_d;

    logic              ram_we;
    logic              accept;
    logic              hold;
    logic              misalign;
    logic              out_of_range;
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] ram_rdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && prog_done) begin
            state_d = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_ready = 1'b0;
        ram_we      = 1'b0;
        case (state_q)
            LOAD:    ram_we      = prog_we;
            RUN:     fetch_ready = !(inst_valid_q && stall);
            default: ;
        endcase
    end

    assign accept = fetch_req && fetch_ready;
    assign hold   = inst_valid_q && stall;

    // Full-width compare on the word index so high address bits fault instead of aliasing.
    assign word_idx     = fetch_addr >> 2;
    assign misalign     = (fetch_addr[1:0] != 2'b00);
    assign out_of_range = (word_idx >= ADDR_W'(DEPTH));

    // ---------------- result and load-count registers ----------------
    always_comb begin
        inst_valid_d = 1'b0;
        fault_code_d = F_NONE;
        prog_count_d = prog_count_q;

        if (hold) begin
            inst_valid_d = inst_valid_q;
            fault_code_d = fault_code_q;
        end else if (accept) begin
            inst_valid_d = 1'b1;
            fault_code_d = imem_fault_t'({out_of_range, misalign});
        end

        if (ram_we && prog_count_q != COUNT_MAX) begin
            prog_count_d = prog_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid_q <= 1'b0;
            fault_code_q <= F_NONE;
            prog_count_q <= '0;
        end else begin
            inst_valid_q <= inst_valid_d;
            fault_code_q <= fault_code_d;
            prog_count_q <= prog_count_d;
        end
    end

    // The RAM read register only loads on an accept, so it naturally holds through a stall.
    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (accept),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

    assign inst_valid = inst_valid_q;
    assign fault_code = fault_code_q;
    assign fault      = (fault_code_q != F_NONE);
    // Gated by the reset-cleared valid flag so inst is NOP_WORD asynchronously in reset.
    assign inst       = (inst_valid_q && fault_code_q == F_NONE) ? ram_rdata : NOP_WORD;
    assign prog_count = prog_count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_done;
    logic [6:0]  prog_count;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic        fault;
    logic [1:0]  fault_code;

    imem_fetch_unit #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .NOP_WORD (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_done   (prog_done),
        .prog_count  (prog_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: memory image plus the currently expected decode-side view.
    logic [31:0] ref_mem [DEPTH];
    bit          m_run;
    int          m_count;
    bit          m_valid;
    logic [31:0] m_inst;
    int          m_code;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_count = 0;
        m_valid = 0;
        m_inst  = 32'h0;
        m_code  = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(m_valid));
        chk({tag, ".inst"},       64'(inst),       64'(m_inst));
        chk({tag, ".fault"},      64'(fault),      64'(m_code != 0));
        chk({tag, ".fault_code"}, 64'(fault_code), 64'(m_code));
        chk({tag, ".prog_count"}, 64'(prog_count), 64'(m_count));
    endtask

    // One clock with the currently driven inputs; inputs must be stable before the negedge.
    task automatic tick(input string tag);
        bit exp_rdy;
        bit acc;
        int widx;
        @(negedge clk);
        exp_rdy = m_run && !(m_valid && stall);
        chk({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(exp_rdy));
        acc = fetch_req && exp_rdy;
        if (!m_run) begin
            if (prog_we) begin
                ref_mem[prog_addr] = prog_data;
                if (m_count < DEPTH) m_count++;
            end
            if (prog_done) m_run = 1;
        end
        if (m_valid && stall) begin
            // result holds
        end else if (acc) begin
            widx    = int'(fetch_addr / 4);
            m_code  = ((fetch_addr / 4) >= DEPTH ? 2 : 0) + ((fetch_addr % 4) != 0 ? 1 : 0);
            m_valid = 1;
            m_inst  = (m_code != 0) ? 32'h0 : ref_mem[widx];
        end else begin
            m_valid = 0;
            m_inst  = 32'h0;
            m_code  = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        prog_we    = 0;
        prog_addr  = '0;
        prog_data  = '0;
        prog_done  = 0;
        fetch_req  = 0;
        fetch_addr = '0;
        stall      = 0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        idle_inputs();
        fetch_req  = 1;
        fetch_addr = a;
        tick(tag);
    endtask

    logic [31:0] prog_img [4];
    int r;

    initial begin
        prog_img[0] = 32'h018A5020;
        prog_img[1] = 32'h20090005;
        prog_img[2] = 32'h00000000;
        prog_img[3] = 32'hAC090004;

        idle_inputs();
        rst = 1;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.fetch_ready", 64'(fetch_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 0;

        // Request while loading must be refused.
        fetch("load_req", 32'h0);

        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            prog_we   = 1;
            prog_addr = 6'(i);
            prog_data = prog_img[i];
            tick("load");
        end
        idle_inputs();
        prog_done = 1;
        tick("done");
        chk("count_after_load", 64'(prog_count), 64'(4));

        // Back-to-back fetches, then one idle cycle.
        fetch("b2b0", 32'h0);
        chk("b2b0.value", 64'(inst), 64'h018A5020);
        fetch("b2b1", 32'h4);
        fetch("b2b2", 32'h8);
        idle_inputs();
        tick("idle");

        fetch("misalign", 32'h6);
        chk("misalign.code", 64'(fault_code), 64'(1));
        fetch("range", 32'h100);
        chk("range.code", 64'(fault_code), 64'(2));
        fetch("both", 32'h102);
        chk("both.code", 64'(fault_code), 64'(3));
        fetch("last_word", 32'hFC);

        // Stall holds the result and blocks new requests.
        fetch("stall_req", 32'h4);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            stall      = 1;
            fetch_req  = 1;
            fetch_addr = 32'h8;
            tick("stall_hold");
        end
        chk("stall.value", 64'(inst), 64'h20090005);
        fetch("stall_release", 32'h8);
        idle_inputs();
        stall = 1;
        tick("stall_idle");

        // Writes in RUN are ignored.
        idle_inputs();
        prog_we   = 1;
        prog_addr = 6'd0;
        prog_data = 32'hFFFFFFFF;
        prog_done = 1;
        tick("run_write");
        fetch("after_run_write", 32'h0);
        chk("run_write.value", 64'(inst), 64'h018A5020);

        // Asynchronous reset between edges while a result is valid.
        fetch("pre_rst", 32'h4);
        #2;
        rst = 1;
        model_reset();
        #1;
        check_outputs("async_rst");
        chk("async_rst.fetch_ready", 64'(fetch_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();
        prog_done = 1;
        tick("done2");
        fetch("retained", 32'h0);
        chk("retained.value", 64'(inst), 64'h018A5020);

        // Full random load with overrun to exercise count saturation.
        rst = 1;
        model_reset();
        #1;
        rst = 0;
        for (int i = 0; i < DEPTH + 6; i++) begin
            idle_inputs();
            prog_we   = 1;
            prog_addr = 6'(i % DEPTH);
            prog_data = $urandom;
            tick("rload");
        end
        chk("count_saturated", 64'(prog_count), 64'(DEPTH));
        idle_inputs();
        prog_done = 1;
        prog_we   = 1;
        prog_addr = 6'd5;
        prog_data = $urandom;
        tick("rdone");

        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            fetch_req = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       fetch_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) fetch_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
            else if (r == 8) fetch_addr = $urandom;
            else             fetch_addr = 32'hFC + 32'($urandom_range(0, 5));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
